// File: rtl/picorv32_ddr_bridge_if.sv
// picorv32_ddr_bridge_if: PicoRV32 native bus, DDR backend, MMIO port and error capture signals
interface picorv32_ddr_bridge_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  mem_valid;
  logic                  mem_instr;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;
  logic                  ddr_rd_req;
  logic                  ddr_wr_req;
  logic [ADDR_WIDTH-1:0] ddr_addr;
  logic [31:0]           ddr_wr_data;
  logic [31:0]           ddr_rd_data;
  logic                  ddr_rd_valid;
  logic                  io_valid;
  logic                  io_instr;
  logic [31:0]           io_addr;
  logic [31:0]           io_wdata;
  logic [3:0]            io_wstrb;
  logic [31:0]           io_rdata;
  logic                  io_ready;
  logic                  err_valid;
  logic [31:0]           err_addr;
  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
           ddr_rd_data, ddr_rd_valid, io_rdata, io_ready,
    output mem_ready, mem_rdata, ddr_rd_req, ddr_wr_req, ddr_addr, ddr_wr_data,
           io_valid, io_instr, io_addr, io_wdata, io_wstrb, err_valid, err_addr
  );
  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
           ddr_rd_data, ddr_rd_valid, io_rdata, io_ready,
    input  mem_ready, mem_rdata, ddr_rd_req, ddr_wr_req, ddr_addr, ddr_wr_data,
           io_valid, io_instr, io_addr, io_wdata, io_wstrb, err_valid, err_addr
  );
endinterface

// File: rtl/picorv32_ddr_bridge.sv
// picorv32_ddr_bridge: decodes PicoRV32 accesses to DDR (with byte-strobe RMW), MMIO or an error
// response, with a per-access wait timeout and capture of the last faulting address.
module picorv32_ddr_bridge #(
  parameter int          ADDR_WIDTH     = 10,
  parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE      = 32'h1000_0000,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input logic clk,
  input logic resetn,
  picorv32_ddr_bridge_if.slave bus
);
  typedef enum logic [2:0] {IDLE, DDR_RD, RMW_RD, DDR_WR, IO, RESP, ERR} state_t;
  state_t      state, state_n;
  logic [31:0] addr_q, wdata_q, merged, rdata_n;
  logic [3:0]  wstrb_q;
  logic        instr_q, ram_hit, io_hit, waiting, resp, expired;
  logic [15:0] cnt;
  assign bus.ddr_addr = addr_q[ADDR_WIDTH+1:2];
  assign bus.io_addr  = addr_q;
  assign bus.io_wdata = wdata_q;
  assign bus.io_wstrb = wstrb_q;
  assign bus.io_instr = instr_q;
  always_comb begin
    ram_hit = bus.mem_addr[31:ADDR_WIDTH+2] == RAM_BASE[31:ADDR_WIDTH+2];
    io_hit  = bus.mem_addr[31:16] == MMIO_BASE[31:16];
    waiting = state inside {DDR_RD, RMW_RD, IO};
    resp    = state == IO ? bus.io_ready : bus.ddr_rd_valid;
    // a response in the limit cycle still wins over the timeout
    expired = cnt == 16'(TIMEOUT_CYCLES - 1) && !resp;
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : bus.ddr_rd_data[8*i +: 8];
    state_n = state;
    case (state)
      IDLE: if (bus.mem_valid)
        state_n = !ram_hit ? (io_hit ? IO : ERR) :
                  bus.mem_wstrb == 4'h0 ? DDR_RD :
                  bus.mem_wstrb == 4'hF ? DDR_WR : RMW_RD;
      DDR_RD, RMW_RD, IO:
        state_n = resp ? (state == RMW_RD ? DDR_WR : RESP) : expired ? ERR : state;
      DDR_WR: state_n = RESP;
      default: state_n = IDLE;
    endcase
    rdata_n = state_n == ERR ? ERR_RDATA :
              state_n != RESP || wstrb_q != 4'h0 ? 32'h0 :
              state == IO ? bus.io_rdata : bus.ddr_rd_data;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state           <= IDLE;
      cnt             <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      instr_q         <= 1'b0;
      bus.ddr_wr_data <= '0;
      bus.ddr_rd_req  <= 1'b0;
      bus.ddr_wr_req  <= 1'b0;
      bus.io_valid    <= 1'b0;
      bus.mem_ready   <= 1'b0;
      bus.mem_rdata   <= '0;
      bus.err_valid   <= 1'b0;
      bus.err_addr    <= '0;
    end else begin
      state <= state_n;
      cnt   <= waiting && state_n == state ? cnt + 16'd1 : '0;
      if (state == IDLE && bus.mem_valid) begin
        addr_q          <= bus.mem_addr;
        wdata_q         <= bus.mem_wdata;
        wstrb_q         <= bus.mem_wstrb;
        instr_q         <= bus.mem_instr;
        bus.ddr_wr_data <= bus.mem_wdata;
      end
      if (state == RMW_RD && resp) bus.ddr_wr_data <= merged;
      bus.ddr_rd_req <= state == IDLE && (state_n == DDR_RD || state_n == RMW_RD);
      bus.ddr_wr_req <= state_n == DDR_WR;
      bus.io_valid   <= state_n == IO;
      bus.mem_ready  <= state_n == RESP || state_n == ERR;
      bus.err_valid  <= state_n == ERR;
      bus.mem_rdata  <= rdata_n;
      if (state_n == ERR) bus.err_addr <= state == IDLE ? bus.mem_addr : addr_q;
    end
endmodule

// File: tb/tb_picorv32_ddr_bridge.sv
// tb_picorv32_ddr_bridge: directed scenarios against a one-cycle DDR model and a scripted MMIO responder
module tb_picorv32_ddr_bridge;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  picorv32_ddr_bridge_if #(.ADDR_WIDTH(10)) b();
  picorv32_ddr_bridge #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(8)) dut (.clk(clk), .resetn(resetn), .bus(b));
  logic [31:0] mem [1024];
  int rd_reqs = 0, wr_reqs = 0, io_cycles = 0, both = 0;
  logic [9:0]  last_wr_addr;
  logic [31:0] last_wr_data;
  int errors = 0, checks = 0;
  int io_held, io_bad;
  always @(posedge clk) begin
    b.ddr_rd_valid <= b.ddr_rd_req;
    b.ddr_rd_data  <= mem[b.ddr_addr];
    if (b.ddr_rd_req) rd_reqs <= rd_reqs + 1;
    if (b.ddr_wr_req) begin
      mem[b.ddr_addr] <= b.ddr_wr_data;
      wr_reqs         <= wr_reqs + 1;
      last_wr_addr    <= b.ddr_addr;
      last_wr_data    <= b.ddr_wr_data;
    end
    if (b.io_valid) io_cycles <= io_cycles + 1;
    if (b.ddr_rd_req && b.ddr_wr_req) both <= both + 1;
  end
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic instr, output logic [31:0] rd, output int lat, output logic ev);
    @(negedge clk);
    b.mem_valid = 1'b1; b.mem_addr = a; b.mem_wdata = d; b.mem_wstrb = s; b.mem_instr = instr;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!b.mem_ready && lat < 200);
    rd = b.mem_rdata;
    ev = b.err_valid;
    if (!b.mem_ready) begin
      errors++; checks++;
      $display("FAIL access_timeout addr=%h no mem_ready within %0d cycles", a, lat);
    end
    b.mem_valid = 1'b0; b.mem_wstrb = 4'h0; b.mem_instr = 1'b0;
  endtask
  task automatic io_respond(input int delay, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic instr, input logic [31:0] rdata);
    int guard = 0;
    io_held = 0; io_bad = 0;
    while (!b.io_valid && guard < 50) begin @(negedge clk); guard++; end
    while (b.io_valid && guard < 200) begin
      io_held++;
      if ({b.io_addr, b.io_wdata, b.io_wstrb, b.io_instr} !== {a, d, s, instr}) io_bad++;
      b.io_ready = (io_held == delay + 1);
      b.io_rdata = rdata;
      @(negedge clk); guard++;
    end
    b.io_ready = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({b.mem_ready, b.ddr_rd_req, b.ddr_wr_req, b.io_valid, b.err_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got=%b exp=00000", {b.mem_ready, b.ddr_rd_req, b.ddr_wr_req, b.io_valid, b.err_valid});
    end
    checks++;
    if ({b.mem_rdata, b.err_addr, b.io_addr, b.ddr_wr_data} !== 128'h0) begin
      errors++; $display("FAIL reset_data rdata=%h err_addr=%h io_addr=%h wr_data=%h exp=0", b.mem_rdata, b.err_addr, b.io_addr, b.ddr_wr_data);
    end
    resetn = 1'b1;
  endtask
  task automatic test_full_write_read();
    logic [31:0] rd; int lat; logic ev; int wr0;
    wr0 = wr_reqs;
    access(32'h10, 32'hCAFE_BABE, 4'hF, 1'b0, rd, lat, ev);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata got=%h exp=0", rd); end
    checks++; if (wr_reqs - wr0 !== 1) begin errors++; $display("FAIL wr_pulses got=%0d exp=1", wr_reqs - wr0); end
    checks++; if (last_wr_addr !== 10'd4) begin errors++; $display("FAIL wr_addr got=%0d exp=4", last_wr_addr); end
    checks++; if (mem[4] !== 32'hCAFE_BABE) begin errors++; $display("FAIL wr_mem got=%h exp=cafebabe", mem[4]); end
    access(32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ev);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'hCAFE_BABE) begin errors++; $display("FAIL rd_data got=%h exp=cafebabe", rd); end
    @(negedge clk);
    checks++; if (b.mem_ready !== 1'b0) begin errors++; $display("FAIL ready_width got=%b exp=0", b.mem_ready); end
  endtask
  task automatic test_rmw();
    logic [31:0] rd; int lat; logic ev; int wr0, rd0;
    access(32'h20, 32'h1122_3344, 4'hF, 1'b0, rd, lat, ev);
    wr0 = wr_reqs; rd0 = rd_reqs;
    access(32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, rd, lat, ev);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rmw_latency got=%0d exp=4", lat); end
    checks++; if (rd_reqs - rd0 !== 1) begin errors++; $display("FAIL rmw_rd_pulses got=%0d exp=1", rd_reqs - rd0); end
    checks++; if (wr_reqs - wr0 !== 1) begin errors++; $display("FAIL rmw_wr_pulses got=%0d exp=1", wr_reqs - wr0); end
    checks++; if (last_wr_data !== 32'h11BB_33DD) begin errors++; $display("FAIL rmw_merge got=%h exp=11bb33dd", last_wr_data); end
    checks++; if (last_wr_addr !== 10'd8) begin errors++; $display("FAIL rmw_addr got=%0d exp=8", last_wr_addr); end
    access(32'h20, 32'h0, 4'h0, 1'b0, rd, lat, ev);
    checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL rmw_readback got=%h exp=11bb33dd", rd); end
    access(32'hFFC, 32'h0BAD_CAFE, 4'hF, 1'b0, rd, lat, ev);
    checks++; if (last_wr_addr !== 10'd1023) begin errors++; $display("FAIL top_addr got=%0d exp=1023", last_wr_addr); end
  endtask
  task automatic test_unmapped();
    logic [31:0] rd; int lat; logic ev; int rd0, wr0, io0;
    rd0 = rd_reqs; wr0 = wr_reqs; io0 = io_cycles;
    access(32'h2000_0000, 32'h0, 4'h0, 1'b0, rd, lat, ev);
    checks++; if (lat !== 1) begin errors++; $display("FAIL unmap_latency got=%0d exp=1", lat); end
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL unmap_rdata got=%h exp=ffffffff", rd); end
    checks++; if (ev !== 1'b1) begin errors++; $display("FAIL unmap_err_valid got=%b exp=1", ev); end
    checks++; if (b.err_addr !== 32'h2000_0000) begin errors++; $display("FAIL unmap_err_addr got=%h exp=20000000", b.err_addr); end
    checks++;
    if (rd_reqs != rd0 || wr_reqs != wr0 || io_cycles != io0) begin
      errors++; $display("FAIL unmap_no_req rd=%0d wr=%0d io=%0d exp=0", rd_reqs - rd0, wr_reqs - wr0, io_cycles - io0);
    end
    @(negedge clk);
    checks++; if (b.err_valid !== 1'b0) begin errors++; $display("FAIL err_pulse_width got=%b exp=0", b.err_valid); end
  endtask
  task automatic test_mmio_write();
    logic [31:0] rd; int lat; logic ev; int rd0, wr0;
    rd0 = rd_reqs; wr0 = wr_reqs;
    fork
      access(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, rd, lat, ev);
      io_respond(5, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h1234_5678);
    join
    checks++; if (io_held !== 6) begin errors++; $display("FAIL io_held got=%0d exp=6", io_held); end
    checks++; if (io_bad !== 0) begin errors++; $display("FAIL io_stable unstable_cycles=%0d exp=0", io_bad); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL io_wr_latency got=%0d exp=7", lat); end
    checks++; if (rd !== 32'h0 || ev !== 1'b0) begin errors++; $display("FAIL io_wr_resp rdata=%h err=%b exp=0/0", rd, ev); end
    checks++; if (rd_reqs != rd0 || wr_reqs != wr0) begin errors++; $display("FAIL io_ddr_quiet rd=%0d wr=%0d exp=0", rd_reqs - rd0, wr_reqs - wr0); end
    checks++; if (b.err_addr !== 32'h2000_0000) begin errors++; $display("FAIL err_addr_hold got=%h exp=20000000", b.err_addr); end
  endtask
  task automatic test_io_limit();
    logic [31:0] rd; int lat; logic ev;
    fork
      access(32'h1000_0010, 32'h0, 4'h0, 1'b0, rd, lat, ev);
      io_respond(7, 32'h1000_0010, 32'h0, 4'h0, 1'b0, 32'h0BAD_F00D);
    join
    checks++; if (io_held !== 8) begin errors++; $display("FAIL limit_held got=%0d exp=8", io_held); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL limit_latency got=%0d exp=9", lat); end
    checks++; if (rd !== 32'h0BAD_F00D || ev !== 1'b0) begin errors++; $display("FAIL limit_resp rdata=%h err=%b exp=0badf00d/0", rd, ev); end
  endtask
  task automatic test_timeout();
    logic [31:0] rd; int lat; logic ev; int rd0;
    fork
      access(32'h1000_0008, 32'h0, 4'h0, 1'b0, rd, lat, ev);
      io_respond(-1, 32'h1000_0008, 32'h0, 4'h0, 1'b0, 32'h5555_5555);
    join
    checks++; if (io_held !== 8) begin errors++; $display("FAIL to_held got=%0d exp=8", io_held); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL to_latency got=%0d exp=9", lat); end
    checks++; if (ev !== 1'b1 || rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_resp err=%b rdata=%h exp=1/ffffffff", ev, rd); end
    checks++; if (b.err_addr !== 32'h1000_0008) begin errors++; $display("FAIL to_err_addr got=%h exp=10000008", b.err_addr); end
    @(negedge clk); b.io_ready = 1'b1;
    @(negedge clk); b.io_ready = 1'b0;
    checks++; if ({b.mem_ready, b.io_valid, b.err_valid} !== 3'b0) begin errors++; $display("FAIL late_ready got=%b exp=000", {b.mem_ready, b.io_valid, b.err_valid}); end
    rd0 = rd_reqs;
    access(32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ev);
    checks++; if (rd !== 32'hCAFE_BABE || lat !== 3 || ev !== 1'b0) begin errors++; $display("FAIL post_to_read rdata=%h lat=%0d err=%b exp=cafebabe/3/0", rd, lat, ev); end
    checks++; if (rd_reqs - rd0 !== 1) begin errors++; $display("FAIL post_to_rd_pulses got=%0d exp=1", rd_reqs - rd0); end
  endtask
  task automatic test_reset_mid_rmw();
    logic [31:0] rd; int lat; logic ev; int wr0, g;
    access(32'h30, 32'h5566_7788, 4'hF, 1'b0, rd, lat, ev);
    wr0 = wr_reqs;
    @(negedge clk);
    b.mem_valid = 1'b1; b.mem_addr = 32'h30; b.mem_wdata = 32'hAABB_CCDD; b.mem_wstrb = 4'b0011;
    g = 0;
    do begin @(negedge clk); g++; end while (!b.ddr_rd_req && g < 20);
    checks++; if (b.ddr_rd_req !== 1'b1) begin errors++; $display("FAIL rst_rmw_req got=%b exp=1", b.ddr_rd_req); end
    resetn = 1'b0; b.mem_valid = 1'b0; b.mem_wstrb = 4'h0;
    #1;
    checks++;
    if ({b.mem_ready, b.ddr_rd_req, b.ddr_wr_req, b.io_valid, b.err_valid} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_strobes got=%b exp=00000", {b.mem_ready, b.ddr_rd_req, b.ddr_wr_req, b.io_valid, b.err_valid});
    end
    checks++;
    if ({b.err_addr, b.ddr_addr, b.ddr_wr_data, b.mem_rdata} !== 106'h0) begin
      errors++; $display("FAIL rst_mid_data err_addr=%h ddr_addr=%h wr_data=%h rdata=%h exp=0", b.err_addr, b.ddr_addr, b.ddr_wr_data, b.mem_rdata);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (wr_reqs != wr0) begin errors++; $display("FAIL rst_no_wr got=%0d exp=0", wr_reqs - wr0); end
    checks++; if (mem[12] !== 32'h5566_7788) begin errors++; $display("FAIL rst_mem_word got=%h exp=55667788", mem[12]); end
    access(32'h30, 32'h0, 4'h0, 1'b0, rd, lat, ev);
    checks++; if (rd !== 32'h5566_7788 || lat !== 3) begin errors++; $display("FAIL rst_readback rdata=%h lat=%0d exp=55667788/3", rd, lat); end
  endtask
  initial begin
    b.mem_valid = 1'b0; b.mem_instr = 1'b0; b.mem_addr = '0; b.mem_wdata = '0; b.mem_wstrb = '0;
    b.io_ready = 1'b0; b.io_rdata = '0;
    test_reset();
    test_full_write_read();
    test_rmw();
    test_unmapped();
    test_mmio_write();
    test_io_limit();
    test_timeout();
    test_reset_mid_rmw();
    checks++; if (both != 0) begin errors++; $display("FAIL rd_wr_overlap got=%0d exp=0", both); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
